// File: rtl/ascon_perm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ascon_perm_ctrl_if
// Brief    : Handshake/control bundle between the Ascon top FSM, the round
//            sequencer and the permutation datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface ascon_perm_ctrl_if;
  logic       start_i;
  logic [1:0] rounds_sel_i;
  logic [3:0] round_o;
  logic       select_o;
  logic       enable_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    output start_i,
    output rounds_sel_i,
    input  round_o,
    input  select_o,
    input  enable_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  start_i,
    input  rounds_sel_i,
    output round_o,
    output select_o,
    output enable_o,
    output busy_o,
    output done_o
  );
endinterface
`default_nettype wire

// File: rtl/ascon_perm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ascon_perm_ctrl
// Brief    : Ascon permutation round sequencer (round index, feedback select,
//            state enable, done pulse). ASCON_PERM_P8_EN adds the p8 count.
// Revision : 1.0 - initial release
// ============================================================================
module ascon_perm_ctrl #(
  parameter int LAST_ROUND = 11,
  parameter int ROUNDS_A   = 12,
  parameter int ROUNDS_B   = 6
) (
  input  wire logic          clock_i,
  input  wire logic          reset_i,
  ascon_perm_ctrl_if.slave   bus
);

  localparam logic [3:0] C_LAST = 4'(LAST_ROUND);
`ifdef ASCON_PERM_P8_EN
  localparam int C_ROUNDS_P8 = 8;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t     r_state;
  logic [3:0] r_round;
  logic       r_select;
  logic       r_enable;
  logic       r_busy;
  logic       r_done;

  // The schedule always ends at LAST_ROUND, so shorter runs start later.
  function automatic logic [3:0] first_round(input logic [1:0] sel);
    int n;
    case (sel)
      2'b01:   n = ROUNDS_B;
`ifdef ASCON_PERM_P8_EN
      2'b10:   n = C_ROUNDS_P8;
`endif
      default: n = ROUNDS_A;
    endcase
    return 4'(LAST_ROUND + 1 - n);
  endfunction

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state  <= S_IDLE;
      r_round  <= 4'd0;
      r_select <= 1'b0;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start_i) begin
            r_state  <= S_RUN;
            r_round  <= first_round(bus.rounds_sel_i);
            r_select <= 1'b0;
            r_enable <= 1'b1;
            r_busy   <= 1'b1;
          end else begin
            r_state  <= S_IDLE;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_round < C_LAST) begin
            r_round  <= r_round + 4'd1;
            r_select <= 1'b1;
            r_enable <= 1'b1;
          end else begin
            r_state  <= S_DONE;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_enable <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.round_o  = r_round;
  assign bus.select_o = r_select;
  assign bus.enable_o = r_enable;
  assign bus.busy_o   = r_busy;
  assign bus.done_o   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ascon_perm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_perm_ctrl
// Brief    : Scoreboard bench for the Ascon round sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascon_perm_ctrl;

  typedef struct {
    int         cyc;
    logic [3:0] round;
    logic       sel;
    logic       en;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t e;

  ascon_perm_ctrl_if bus ();

  ascon_perm_ctrl dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every enable or done cycle must match the head of the queue.
  always @(negedge clk) begin
    if (bus.enable_o || bus.done_o) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output cyc=%0d round=%0d en=%0b done=%0b (none expected)",
                 cyc, bus.round_o, bus.enable_o, bus.done_o);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || bus.round_o != e.round || bus.select_o != e.sel ||
            bus.enable_o != e.en || bus.busy_o != e.busy || bus.done_o != e.done) begin
          n_err++;
          $display("FAIL seq_output got cyc=%0d round=%0d sel=%0b en=%0b busy=%0b done=%0b, want cyc=%0d round=%0d sel=%0b en=%0b busy=%0b done=%0b",
                   cyc, bus.round_o, bus.select_o, bus.enable_o, bus.busy_o, bus.done_o,
                   e.cyc, e.round, e.sel, e.en, e.busy, e.done);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Expected enable cycles start at cycle s; npush < n models an aborted run.
  task automatic push_run(input int s, input int n, input int npush);
    int first;
    first = 12 - n;
    for (int i = 0; i < npush; i++)
      q.push_back('{s + i, 4'(first + i), (i != 0), 1'b1, 1'b1, 1'b0});
    if (npush == n)
      q.push_back('{s + n, 4'd11, 1'b1, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_round"},  int'(bus.round_o),  0);
    check({tag, "_select"}, int'(bus.select_o), 0);
    check({tag, "_enable"}, int'(bus.enable_o), 0);
    check({tag, "_busy"},   int'(bus.busy_o),   0);
    check({tag, "_done"},   int'(bus.done_o),   0);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout got pending=%0d want=0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic single_run(input logic [1:0] sel, input int n);
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.rounds_sel_i = sel;
    push_run(cyc + 1, n, n);
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_drain();
  endtask

  initial begin
    int s;
    rst_n            = 1'b0;
    bus.start_i      = 1'b0;
    bus.rounds_sel_i = 2'b00;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    single_run(2'b00, 12);
    single_run(2'b01, 6);
    single_run(2'b11, 12);
`ifdef ASCON_PERM_P8_EN
    single_run(2'b10, 8);
`else
    single_run(2'b10, 12);
`endif

    // Back-to-back: start held through DONE; sel changes mid-run.
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.rounds_sel_i = 2'b00;
    s = cyc + 1;
    push_run(s, 12, 12);
    push_run(s + 13, 6, 6);
    @(negedge clk);
    bus.rounds_sel_i = 2'b01;
    repeat (13) @(negedge clk);
    bus.start_i = 1'b0;
    wait_drain();

    // Start and sel change at round 5 are ignored.
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.rounds_sel_i = 2'b00;
    push_run(cyc + 1, 12, 12);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    bus.start_i      = 1'b1;
    bus.rounds_sel_i = 2'b01;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_drain();

    // Reset at round 7 aborts with no done.
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.rounds_sel_i = 2'b00;
    push_run(cyc + 1, 12, 8);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_pending", q.size(), 0);
    q.delete();

    single_run(2'b01, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
